// File: rtl/gcd_go_sequencer.sv
// Initiator-side sequencer for a GCD core. It drives x/y/go with setup, go-pulse and settle
// timing, then returns d over valid/ready. Optional macro GCD_SEQ_STABLE_CHECK_EN adds res_err_o.
module gcd_go_sequencer #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned GO_CYC     = 4,
    parameter int unsigned SETTLE_CYC = 10
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             req_valid_i,
    input  logic [WIDTH-1:0] req_x_i,
    input  logic [WIDTH-1:0] req_y_i,
    output logic             req_ready_o,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o,
    output logic             go_o,
    input  logic [WIDTH-1:0] d_i,
    output logic             res_valid_o,
    output logic [WIDTH-1:0] res_d_o,
    input  logic             res_ready_i,
`ifdef GCD_SEQ_STABLE_CHECK_EN
    output logic             res_err_o,
`endif
    output logic [7:0]       res_count_o
);

    // Phase counter counts down from CYC-1; the state is left when it reaches zero.
    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] GO_LD     = 8'(GO_CYC - 1);
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_GO    = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [7:0]       cnt_r;
    logic [7:0]       cnt_nxt_s;
    logic [WIDTH-1:0] x_nxt_s;
    logic [WIDTH-1:0] y_nxt_s;
    logic [WIDTH-1:0] res_d_nxt_s;
    logic             go_nxt_s;
    logic             res_valid_nxt_s;
    logic [7:0]       res_count_nxt_s;
`ifdef GCD_SEQ_STABLE_CHECK_EN
    logic [WIDTH-1:0] d_prev_r;
    logic [WIDTH-1:0] d_prev_nxt_s;
    logic             res_err_nxt_s;
`endif

    assign req_ready_o = (state_r == ST_IDLE) && !RESET;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        x_nxt_s         = x_o;
        y_nxt_s         = y_o;
        res_d_nxt_s     = res_d_o;
        go_nxt_s        = go_o;
        res_valid_nxt_s = res_valid_o;
        res_count_nxt_s = res_count_o;
`ifdef GCD_SEQ_STABLE_CHECK_EN
        d_prev_nxt_s    = d_prev_r;
        res_err_nxt_s   = res_err_o;
`endif
        case (state_r)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    x_nxt_s = req_x_i;
                    y_nxt_s = req_y_i;
                    // A zero operand would hang a subtractive core: answer directly.
                    if ((req_x_i == '0) || (req_y_i == '0)) begin
                        state_nxt_s     = ST_DONE;
                        cnt_nxt_s       = 8'd0;
                        res_d_nxt_s     = req_x_i | req_y_i;
                        res_valid_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_SETUP;
                        cnt_nxt_s   = SETUP_LD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == 8'd0) begin
                    state_nxt_s = ST_GO;
                    cnt_nxt_s   = GO_LD;
                    go_nxt_s    = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end
            end
            ST_GO: begin
                if (cnt_r == 8'd0) begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = SETTLE_LD;
                    go_nxt_s    = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 8'd0) begin
                    state_nxt_s     = ST_DONE;
                    cnt_nxt_s       = 8'd0;
                    res_d_nxt_s     = d_i;
                    res_valid_nxt_s = 1'b1;
`ifdef GCD_SEQ_STABLE_CHECK_EN
                    res_err_nxt_s   = (d_i != d_prev_r);
`endif
                end else begin
                    cnt_nxt_s = cnt_r - 8'd1;
`ifdef GCD_SEQ_STABLE_CHECK_EN
                    if (cnt_r == 8'd1) begin
                        d_prev_nxt_s = d_i;
                    end else begin
                        d_prev_nxt_s = d_prev_r;
                    end
`endif
                end
            end
            ST_DONE: begin
                if (res_ready_i) begin
                    state_nxt_s     = ST_IDLE;
                    cnt_nxt_s       = 8'd0;
                    res_valid_nxt_s = 1'b0;
                    res_count_nxt_s = res_count_o + 8'd1;
`ifdef GCD_SEQ_STABLE_CHECK_EN
                    res_err_nxt_s   = 1'b0;
`endif
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                cnt_nxt_s       = 8'd0;
                go_nxt_s        = 1'b0;
                res_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            x_o         <= '0;
            y_o         <= '0;
            go_o        <= 1'b0;
            res_valid_o <= 1'b0;
            res_d_o     <= '0;
            res_count_o <= 8'd0;
`ifdef GCD_SEQ_STABLE_CHECK_EN
            d_prev_r    <= '0;
            res_err_o   <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            x_o         <= x_nxt_s;
            y_o         <= y_nxt_s;
            go_o        <= go_nxt_s;
            res_valid_o <= res_valid_nxt_s;
            res_d_o     <= res_d_nxt_s;
            res_count_o <= res_count_nxt_s;
`ifdef GCD_SEQ_STABLE_CHECK_EN
            d_prev_r    <= d_prev_nxt_s;
            res_err_o   <= res_err_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_gcd_go_sequencer.sv
// Scoreboard bench for gcd_go_sequencer with a behavioural GCD core attached.
module tb_gcd_go_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [3:0] req_x;
    logic [3:0] req_y;
    logic       req_ready;
    logic [3:0] x_o;
    logic [3:0] y_o;
    logic       go;
    logic [3:0] d_core;
    logic [3:0] d_in;
    logic       glitch;
    logic       res_valid;
    logic [3:0] res_d;
    logic       res_ready;
    logic [7:0] res_count;
`ifdef GCD_SEQ_STABLE_CHECK_EN
    logic       res_err;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] sb[$];
    logic [3:0] sb_exp;

    always #5 clk = ~clk;

    gcd_go_sequencer dut (
        .CLK(clk), .RESET(reset),
        .req_valid_i(req_valid), .req_x_i(req_x), .req_y_i(req_y), .req_ready_o(req_ready),
        .x_o(x_o), .y_o(y_o), .go_o(go), .d_i(d_in),
        .res_valid_o(res_valid), .res_d_o(res_d), .res_ready_i(res_ready),
`ifdef GCD_SEQ_STABLE_CHECK_EN
        .res_err_o(res_err),
`endif
        .res_count_o(res_count)
    );

    function automatic logic [3:0] gcd(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p = a;
        logic [3:0] q = b;
        logic [3:0] t;
        while (q != 4'd0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Behavioural core: result becomes available while go is high.
    always @(posedge clk) begin
        if (reset) d_core <= 4'd0;
        else if (go) d_core <= gcd(x_o, y_o);
    end
    assign d_in = glitch ? (d_core ^ 4'd1) : d_core;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares each handed-off result against the scoreboard.
    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got %0d, expected none", res_d);
            end else begin
                sb_exp = sb.pop_front();
                if (res_d !== sb_exp) begin
                    n_err++;
                    $display("FAIL res_d: got %0d, expected %0d", res_d, sb_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] x, input logic [3:0] y, input logic [3:0] e,
                        output int ok);
        req_x = x;
        req_y = y;
        req_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 60 && ok == 0; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
            tick();
        end
        req_valid = 1'b0;
        req_x = 4'($urandom);
        req_y = 4'($urandom);
        if (ok != 0) sb.push_back(e);
        else check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input int glitch_at, output int lat, output logic [31:0] gomask,
                              output bit ready_seen);
        lat = 1;
        gomask = 32'd0;
        ready_seen = 1'b0;
        while (1) begin
            if (go && lat < 32) gomask[lat] = 1'b1;
            if (req_ready) ready_seen = 1'b1;
            if (res_valid || lat >= 40) break;
            tick();
            lat++;
            if (lat == glitch_at) glitch = 1'b1;
        end
        glitch = 1'b0;
    endtask

    task automatic run_one(input logic [3:0] x, input logic [3:0] y, input logic [3:0] e,
                           input int lat_exp, input logic [31:0] go_exp, input int glitch_at);
        int ok;
        int lat;
        logic [31:0] gm;
        bit rs;
        send(x, y, e, ok);
        if (ok != 0) begin
            wait_valid(glitch_at, lat, gm, rs);
            check("latency", lat, lat_exp);
            check("go_window", gm, go_exp);
            check("ready_while_busy", {31'd0, rs}, 32'd0);
`ifdef GCD_SEQ_STABLE_CHECK_EN
            check("res_err", {31'd0, res_err}, {31'd0, glitch_at != 0});
`endif
            tick();
        end
    endtask

    initial begin
        int ok;
        int lat;
        logic [31:0] gm;
        bit rs;
        bit hold_ok;

        reset = 1'b1; req_valid = 1'b0; req_x = 4'd0; req_y = 4'd0;
        res_ready = 1'b1; glitch = 1'b0;
        repeat (3) tick();
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_go", {31'd0, go}, 32'd0);
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_count", {24'd0, res_count}, 32'd0);
        check("rst_xy", {24'd0, x_o, y_o}, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_ready", {31'd0, req_ready}, 32'd1);

        // Basic request and operand hold after completion.
        run_one(4'd8, 4'd12, 4'd4, 17, 32'h78, 0);
        check("count_1", {24'd0, res_count}, 32'd1);
        check("xy_hold", {24'd0, x_o, y_o}, {24'd0, 4'd8, 4'd12});

        run_one(4'd3, 4'd8, 4'd1, 17, 32'h78, 0);
        run_one(4'd15, 4'd10, 4'd5, 17, 32'h78, 0);
        check("count_3", {24'd0, res_count}, 32'd3);

        // Zero operands bypass the core.
        run_one(4'd0, 4'd9, 4'd9, 1, 32'd0, 0);
        run_one(4'd0, 4'd0, 4'd0, 1, 32'd0, 0);
        check("count_5", {24'd0, res_count}, 32'd5);

        // Backpressure: result held, new request stalled.
        res_ready = 1'b0;
        send(4'd9, 4'd9, 4'd9, ok);
        wait_valid(0, lat, gm, rs);
        check("bp_latency", lat, 32'd17);
        req_valid = 1'b1; req_x = 4'd1; req_y = 4'd2;
        hold_ok = 1'b1;
        repeat (20) begin
            tick();
            if (!(res_valid && res_d == 4'd9 && !req_ready && x_o == 4'd9)) hold_ok = 1'b0;
        end
        check("bp_hold", {31'd0, hold_ok}, 32'd1);
        res_ready = 1'b1;
        run_one(4'd1, 4'd2, 4'd1, 17, 32'h78, 0);
        check("count_7", {24'd0, res_count}, 32'd7);

        // Reset during GO drops the request.
        send(4'd8, 4'd12, 4'd4, ok);
        tick(); tick();
        check("go_high", {31'd0, go}, 32'd1);
        reset = 1'b1;
        tick();
        sb.delete();
        check("mid_rst_go", {31'd0, go}, 32'd0);
        check("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        check("mid_rst_count", {24'd0, res_count}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        run_one(4'd8, 4'd12, 4'd4, 17, 32'h78, 0);
        check("post_rst_count", {24'd0, res_count}, 32'd1);

        // Counter wrap.
        for (int i = 0; i < 254; i++) run_one(4'd0, 4'(i), 4'(i), 1, 32'd0, 0);
        check("count_255", {24'd0, res_count}, 32'd255);
        run_one(4'd7, 4'd0, 4'd7, 1, 32'd0, 0);
        check("count_wrap", {24'd0, res_count}, 32'd0);

`ifdef GCD_SEQ_STABLE_CHECK_EN
        // d changes on the last settle cycle: flagged, and cleared by the handshake.
        run_one(4'd8, 4'd12, 4'd5, 17, 32'h78, 16);
        check("err_clear", {31'd0, res_err}, 32'd0);
`endif

        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
